// File: rtl/key_debounce_pulse.sv
// -----------------------------------------------------------------------------
// key_debounce_pulse
//
// Multi-channel push-button conditioner. Every channel owns a synchroniser
// chain, a counter-based debouncer FSM and an optional auto-repeat generator.
// Channels are fully independent; several may pulse in the same cycle.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   key_in         raw asynchronous key/switch inputs (polarity set by ACTIVE_LOW)
//   key_level      debounced level, 1 = pressed
//   press_pulse    one-cycle pulse when a press is accepted
//   release_pulse  one-cycle pulse when a release is accepted
//   repeat_pulse   one-cycle auto-repeat pulse while held (REPEAT_MASK channels)
//
// Latency: a clean press or release is reported SYNC_STAGES + DB_CYCLES rising
// edges after the first edge that samples the new key_in level.
// -----------------------------------------------------------------------------
module key_debounce_pulse #(
    parameter int                 N_KEYS        = 4,
    parameter bit                 ACTIVE_LOW    = 1'b1,
    parameter int                 SYNC_STAGES   = 3,
    parameter int                 DB_CYCLES     = 1000000,
    parameter logic [N_KEYS-1:0]  REPEAT_MASK   = '0,
    parameter int                 REPEAT_DELAY  = 25000000,
    parameter int                 REPEAT_PERIOD = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse
);

    localparam int DCNT_W   = $clog2(DB_CYCLES + 1);
    localparam int RCNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W   = $clog2(RCNT_MAX + 1);

    localparam logic [DCNT_W-1:0] DB_LAST    = DCNT_W'(DB_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);
    localparam logic [RCNT_W-1:0] RPT_DELAY  = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] RPT_PERIOD = RCNT_W'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan

        // ---------------------------------------------------------------------
        // Synchroniser: presets to the inactive input level so that a reset
        // never looks like a press, and a key held through reset is re-sampled
        // and reported with the full latency.
        // ---------------------------------------------------------------------
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
            end else begin
                // NOTE: sequential state uses non-blocking assignments so every
                // flop samples the pre-edge value of its neighbour.
                sync_q <= {sync_q[SYNC_STAGES-2:0], key_in[i]};
            end
        end

        // Polarity-normalised sample: 1 = pressed.
        assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

        // ---------------------------------------------------------------------
        // Debounce / repeat FSM
        // ---------------------------------------------------------------------
        state_t            state_q,     state_d;
        logic [DCNT_W-1:0] dcnt_q,      dcnt_d;
        logic [RCNT_W-1:0] rcnt_q,      rcnt_d;
        logic              rep_phase_q, rep_phase_d;  // 0: waiting for first repeat
        logic              level_q,     level_d;
        logic              press_q,     press_d;
        logic              release_q,   release_d;
        logic              repeat_q,    repeat_d;

        logic [RCNT_W-1:0] rcnt_inc;
        logic [RCNT_W-1:0] rcnt_limit;

        assign rcnt_inc   = rcnt_q + RCNT_W'(1);
        // The first repeat waits REPEAT_DELAY cycles, later ones REPEAT_PERIOD.
        // Selecting the limit (rather than reloading an offset) stays correct
        // when REPEAT_PERIOD exceeds REPEAT_DELAY.
        assign rcnt_limit = rep_phase_q ? RPT_PERIOD : RPT_DELAY;

        always_comb begin
            // NOTE: every signal gets a default before the case so no path can
            // leave one unassigned and infer a latch.
            state_d     = state_q;
            dcnt_d      = dcnt_q;
            rcnt_d      = rcnt_q;
            rep_phase_d = rep_phase_q;
            level_d     = level_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            repeat_d    = 1'b0;

            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_WAIT;
                        dcnt_d  = DCNT_ONE;
                    end
                end

                PRESS_WAIT: begin
                    if (!s) begin
                        // Glitch rejected silently.
                        state_d = IDLE;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DB_LAST) begin
                        state_d     = PRESSED;
                        press_d     = 1'b1;
                        level_d     = 1'b1;
                        dcnt_d      = '0;
                        rcnt_d      = '0;
                        rep_phase_d = 1'b0;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end

                PRESSED: begin
                    if (!s) begin
                        state_d = RELEASE_WAIT;
                        dcnt_d  = DCNT_ONE;
                    end else if (REPEAT_MASK[i]) begin
                        if (rcnt_inc == rcnt_limit) begin
                            repeat_d    = 1'b1;
                            rcnt_d      = '0;
                            rep_phase_d = 1'b1;
                        end else begin
                            rcnt_d = rcnt_inc;
                        end
                    end
                end

                RELEASE_WAIT: begin
                    if (s) begin
                        // Release glitch: back to PRESSED, repeat timing resumes
                        // from where it was.
                        state_d = PRESSED;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DB_LAST) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                        level_d   = 1'b0;
                        dcnt_d    = '0;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q     <= IDLE;
                dcnt_q      <= '0;
                rcnt_q      <= '0;
                rep_phase_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                repeat_q    <= 1'b0;
            end else begin
                state_q     <= state_d;
                dcnt_q      <= dcnt_d;
                rcnt_q      <= rcnt_d;
                rep_phase_q <= rep_phase_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                repeat_q    <= repeat_d;
            end
        end

        assign key_level[i]     = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign repeat_pulse[i]  = repeat_q;

    end : g_chan

endmodule : key_debounce_pulse
